jt49_dcrm_mc: RTL and testbench

Multi-channel, parametrised DC-removal filter for PSG audio. Channels share one datapath under time-multiplexing, with per-channel integrator and error-feedback state. The leak coefficient is 2^-K, and fractional precision F is configurable. Sits between the jt49 channel mixers and the output stage; it replaces per-channel single-width DC removers.

---
 rtl/jt49_pkg.sv | 30 +++
 rtl/jt49_dcrm_core.sv | 53 +++++
 rtl/jt49_dcrm_mc.sv | 135 +++++++++++++
 tb/tb_jt49_dcrm_mc.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jt49_pkg.sv
// Shared definitions for the jt49 DC-removal filter: sweep FSM state
// encoding, state-word width and output clamp limits.
package jt49_pkg;

  // Sweep FSM state; plain constants keep the encoding visible to legacy code.
  typedef logic [0:0] dcrm_state_t;
  localparam dcrm_state_t ST_RUN   = 1'b0;
  localparam dcrm_state_t ST_CLEAR = 1'b1;

  // Integrator / error-feedback word width: sample bits, fraction, two guard bits.
  function automatic int dcrm_aw(input int w, input int f);
    return w + f + 2;
  endfunction

  // Largest value a signed W-bit output can carry.
  function automatic int dcrm_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Smallest value a signed W-bit output can carry.
  function automatic int dcrm_lo(input int w);
    return -(1 << (w - 1));
  endfunction

  // Channel index width; never narrower than one bit.
  function automatic int dcrm_chw(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/jt49_dcrm_core.sv
// Per-sample arithmetic of the DC remover. Purely combinational: given the
// incoming sample and one channel's acc/err it produces the clamped output,
// the bypass value x and the channel's next acc/err.
module jt49_dcrm_core
  import jt49_pkg::*;
#(
  parameter int W = 8,
  parameter int F = 4,
  parameter int K = 4,
  localparam int AW = dcrm_aw(W, F)
) (
  input  logic                 [W-1:0]  din,
  input  logic signed          [AW-1:0] acc,
  input  logic signed          [AW-1:0] err,
  output logic signed          [W-1:0]  x,
  output logic signed          [W-1:0]  dout,
  output logic signed          [AW-1:0] acc_nxt,
  output logic signed          [AW-1:0] err_nxt
);

  localparam int YW = W + 2;
  localparam logic signed [YW-1:0] Y_HI = YW'(dcrm_hi(W));
  localparam logic signed [YW-1:0] Y_LO = YW'(dcrm_lo(W));

  logic signed [YW-1:0] x_w;
  logic signed [YW-1:0] y;
  logic signed [AW-1:0] exact;
  logic signed [AW-1:0] q;
  logic signed [AW-1:0] y_ext;
  logic signed [AW-1:0] y_scaled;

  // Halve the unsigned input, subtract the integrated DC estimate, leak it back.
  always_comb begin
    // NOTE: every always_comb output gets an unconditional value first so no
    // path through the block leaves it unassigned, which would infer a latch.
    dout     = '0;
    x_w      = {3'b000, din[W-1:1]};
    exact    = acc + err;
    q        = exact >>> F;
    y        = x_w - q[YW-1:0];
    y_ext    = {{F{y[YW-1]}}, y};
    // The unclamped difference feeds the integrator so clipping never biases it.
    y_scaled = (y_ext <<< F) >>> K;
    acc_nxt  = acc + y_scaled;
    // Fraction dropped by the truncating shift is carried to the next sample.
    err_nxt  = exact - (q <<< F);
    if (y > Y_HI)      dout = Y_HI[W-1:0];
    else if (y < Y_LO) dout = Y_LO[W-1:0];
    else               dout = y[W-1:0];
    x        = x_w[W-1:0];
  end

endmodule

// File: rtl/jt49_dcrm_mc.sv
// Time-multiplexed multi-channel DC-removal filter for jt49 PSG channels.
// Holds per-channel acc/err state, the RUN/CLEAR sweep FSM and the
// one-cycle-latency output registers; the arithmetic lives in jt49_dcrm_core.
// Optional feature: define JT49_DCRM_BYPASS_EN to add the `bypass` input,
// which passes din>>1 straight through and freezes the channel state.
module jt49_dcrm_mc
  import jt49_pkg::*;
#(
  parameter int W  = 8,
  parameter int CH = 3,
  parameter int F  = 4,
  parameter int K  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cen,
  input  logic                         clr,
`ifdef JT49_DCRM_BYPASS_EN
  input  logic                         bypass,
`endif
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic [dcrm_chw(CH)-1:0]      din_ch,
  input  logic [W-1:0]                 din,
  output logic                         dout_valid,
  output logic [dcrm_chw(CH)-1:0]      dout_ch,
  output logic signed [W-1:0]          dout
);

  localparam int AW  = dcrm_aw(W, F);
  localparam int CHW = dcrm_chw(CH);
  localparam logic [CHW:0]   CH_LIM = (CHW + 1)'(CH);
  localparam logic [CHW-1:0] S_LAST = CHW'(CH - 1);

  logic signed [AW-1:0] acc_q [CH];
  logic signed [AW-1:0] err_q [CH];
  dcrm_state_t          state;
  logic [CHW-1:0]       sweep;

  logic                 ch_ok;
  logic                 take;
  logic                 byp;
  logic [CHW-1:0]       ch_sel;
  logic signed [W-1:0]  core_x;
  logic signed [W-1:0]  core_dout;
  logic signed [AW-1:0] acc_nxt;
  logic signed [AW-1:0] err_nxt;

`ifdef JT49_DCRM_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif

  assign din_ready = (state == ST_RUN);
  assign ch_ok     = ({1'b0, din_ch} < CH_LIM);
  assign take      = cen & din_valid & din_ready & ch_ok;
  // Out-of-range channels never commit, so steering their read to 0 is harmless.
  assign ch_sel    = ch_ok ? din_ch : '0;

  jt49_dcrm_core #(
    .W (W),
    .F (F),
    .K (K)
  ) u_core (
    .din     (din),
    .acc     (acc_q[ch_sel]),
    .err     (err_q[ch_sel]),
    .x       (core_x),
    .dout    (core_dout),
    .acc_nxt (acc_nxt),
    .err_nxt (err_nxt)
  );

  // Sweep FSM: clr (re)starts a one-channel-per-cen-cycle clear of all state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      state <= ST_RUN;
      sweep <= '0;
    end else if (cen) begin
      if (clr) begin
        state <= ST_CLEAR;
        sweep <= '0;
      end else if (state == ST_CLEAR) begin
        if (sweep == S_LAST) begin
          state <= ST_RUN;
          sweep <= '0;
        end else begin
          sweep <= sweep + 1'b1;
        end
      end
    end
  end

  // Per-channel state: sweep zeroes channel s, an accepted sample updates its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the state arrays are a handful of flops, not a RAM, so they take
      // the async reset and a reset always restarts the filter from zero.
      for (int i = 0; i < CH; i++) begin
        acc_q[i] <= '0;
        err_q[i] <= '0;
      end
    end else if (cen) begin
      for (int i = 0; i < CH; i++) begin
        if (state == ST_CLEAR && sweep == CHW'(i)) begin
          acc_q[i] <= '0;
          err_q[i] <= '0;
        end else if (take && !byp && din_ch == CHW'(i)) begin
          acc_q[i] <= acc_nxt;
          err_q[i] <= err_nxt;
        end
      end
    end
  end

  // Output registers: data captured on the accepting edge, strobe for one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout_ch    <= '0;
      dout       <= '0;
    end else begin
      // take already includes cen, so the strobe drops on any non-accepting edge.
      dout_valid <= take;
      if (take) begin
        dout_ch <= din_ch;
        dout    <= byp ? core_x : core_dout;
      end
    end
  end

endmodule

// File: tb/tb_jt49_dcrm_mc.sv
// Directed bench for jt49_dcrm_mc at W=8, CH=3, F=4, K=4. Expected values
// are hand-derived from the filter recurrence. Define JT49_DCRM_BYPASS_EN
// to also exercise the bypass port.
module tb_jt49_dcrm_mc;

  typedef struct {
    int ch;
    int din;
    int exp_dout;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic              cen;
  logic              clr;
`ifdef JT49_DCRM_BYPASS_EN
  logic              bypass;
`endif
  logic              din_valid;
  logic              din_ready;
  logic [1:0]        din_ch;
  logic [7:0]        din;
  logic              dout_valid;
  logic [1:0]        dout_ch;
  logic signed [7:0] dout;

  int n_cmp = 0;
  int n_bad = 0;

  jt49_dcrm_mc #(
    .W  (8),
    .CH (3),
    .F  (4),
    .K  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .clr        (clr),
`ifdef JT49_DCRM_BYPASS_EN
    .bypass     (bypass),
`endif
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_ch     (din_ch),
    .din        (din),
    .dout_valid (dout_valid),
    .dout_ch    (dout_ch),
    .dout       (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one sample at the falling edge, observe the registered result one edge later.
  task automatic send(input int ch, input int d, output int got, output int vld);
    din_valid = 1'b1;
    din_ch    = ch[1:0];
    din       = d[7:0];
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    got       = int'(dout);
    vld       = int'(dout_valid);
  endtask

  task automatic send_chk(input string name, input int ch, input int d, input int exp);
    int got, vld;
    send(ch, d, got, vld);
    check({name, "_valid"}, vld, 1);
    check({name, "_ch"}, int'(dout_ch), ch);
    check(name, got, exp);
  endtask

  // Pulse clr for one cen edge and count the falling edges with din_ready low.
  task automatic do_clear(output int n);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    n = 0;
    while (!din_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  vec_t seq_tab [8];
  vec_t mix_tab [9];

  initial begin
    int got, vld, n, maxabs, pulses, bad_strobe, prev_cen;

    seq_tab = '{
      '{0, 200, 100}, '{0, 200, 94}, '{0, 200, 88}, '{0, 200, 82},
      '{0, 200, 78},  '{0, 200, 72}, '{0, 200, 68}, '{0, 200, 64}
    };
    mix_tab = '{
      '{0, 200, 100}, '{1, 0, 0}, '{2, 128, 64},
      '{0, 200, 94},  '{1, 0, 0}, '{2, 128, 60},
      '{0, 200, 88},  '{1, 0, 0}, '{2, 128, 57}
    };

    rst_n     = 1'b0;
    cen       = 1'b1;
    clr       = 1'b0;
`ifdef JT49_DCRM_BYPASS_EN
    bypass    = 1'b0;
`endif
    din_valid = 1'b0;
    din_ch    = '0;
    din       = '0;
    repeat (3) @(negedge clk);
    check("rst_dout", int'(dout), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_dout_ch", int'(dout_ch), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", int'(din_ready), 1);

    // Single channel, constant input: hand-derived decay, back-to-back.
    for (int i = 0; i < 8; i++)
      send_chk($sformatf("seq%0d", i), seq_tab[i].ch, seq_tab[i].din, seq_tab[i].exp_dout);
    maxabs = 0;
    for (int i = 8; i < 200; i++) begin
      send(0, 200, got, vld);
      if (i >= 150 && (got > maxabs || -got > maxabs)) maxabs = (got < 0) ? -got : got;
    end
    check("settle_valid", vld, 1);
    check("settle_le1", int'(maxabs <= 1), 1);

    // Clear sweep after settling.
    do_clear(n);
    check("clr_len", n, 3);
    send_chk("clr_after", 0, 200, 100);

    // Interleaved channels from clean state.
    do_clear(n);
    check("clr_len2", n, 3);
    for (int i = 0; i < 9; i++)
      send_chk($sformatf("mix%0d", i), mix_tab[i].ch, mix_tab[i].din, mix_tab[i].exp_dout);

    // Sample accepted in the clr cycle is processed, then its state is swept.
    clr       = 1'b1;
    din_valid = 1'b1;
    din_ch    = 2'd0;
    din       = 8'd200;
    @(posedge clk);
    @(negedge clk);
    clr       = 1'b0;
    din_valid = 1'b0;
    check("clr_acc_valid", int'(dout_valid), 1);
    check("clr_acc_dout", int'(dout), 82);
    n = 0;
    while (!din_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("clr_acc_len", n, 3);
    send_chk("clr_acc_after", 0, 200, 100);

    // cen toggling with din_valid held: one strobe per cen-high edge.
    do_clear(n);
    din_valid  = 1'b1;
    din_ch     = 2'd1;
    din        = 8'd0;
    pulses     = 0;
    bad_strobe = 0;
    for (int k = 0; k < 20; k++) begin
      cen      = (k % 2 == 0);
      prev_cen = int'(cen);
      @(posedge clk);
      @(negedge clk);
      if (dout_valid) pulses++;
      if (int'(dout_valid) != prev_cen) bad_strobe++;
    end
    cen = 1'b1;
    check("cen_pulses", pulses, 10);
    check("cen_strobe_err", bad_strobe, 0);
    check("cen_dout", int'(dout), 0);

    // Out-of-range channel: no strobe, outputs and state untouched.
    din_ch = 2'd3;
    din    = 8'd200;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (dout_valid) pulses++;
    end
    din_valid = 1'b0;
    check("bad_ch_pulses", pulses, 0);
    check("bad_ch_dout_ch", int'(dout_ch), 1);
    check("bad_ch_dout", int'(dout), 0);
    send_chk("bad_ch_ch0", 0, 200, 100);
    send_chk("bad_ch_ch1", 1, 200, 100);

    // Reset mid-stream: outputs drop immediately, state restarts.
    send_chk("pre_rst", 2, 128, 64);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_dout", int'(dout), 0);
    check("rst_mid_valid", int'(dout_valid), 0);
    check("rst_mid_ch", int'(dout_ch), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", int'(din_ready), 1);
    send_chk("rst_mid_ch0", 0, 200, 100);
    send_chk("rst_mid_ch2", 2, 128, 64);

    // Reset mid-sweep.
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    check("sweep_ready_lo", int'(din_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_sweep_dout", int'(dout), 0);
    check("rst_sweep_ready", int'(din_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_sweep_ready2", int'(din_ready), 1);
    send_chk("rst_sweep_ch0", 0, 200, 100);

`ifdef JT49_DCRM_BYPASS_EN
    // Bypass passes din>>1 and freezes the channel state.
    do_clear(n);
    bypass = 1'b1;
    for (int i = 0; i < 3; i++)
      send_chk($sformatf("byp%0d", i), 0, 200, 100);
    bypass = 1'b0;
    send_chk("byp_release", 0, 200, 100);
    send_chk("byp_release2", 0, 200, 94);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
